// File: rtl/perf_counter_bank.sv
// Performance-monitor counter bank: NUM_EVENTS event counters plus a cycle counter,
// frozen on processor halt or a cycle-limit watchdog, with a registered read port.
module perf_counter_bank #(
    parameter int unsigned NUM_EVENTS  = 8,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned CYCLE_LIMIT = 100000,
    localparam int unsigned SEL_W      = $clog2(NUM_EVENTS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_i,
    input  logic                  clear_i,
    input  logic                  sat_mode_i,
    input  logic [NUM_EVENTS-1:0] event_i,
    input  logic                  halt_i,
    input  logic [SEL_W-1:0]      rd_sel_i,
    output logic [CNT_W-1:0]      rd_data_o,
    output logic                  running_o,
    output logic                  frozen_o,
    output logic                  timeout_o,
    output logic [NUM_EVENTS:0]   ovf_o
);

    localparam int unsigned NUM_CNT = NUM_EVENTS + 1;
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
    localparam logic [63:0] CycleLimit = 64'(CYCLE_LIMIT);

    typedef enum logic [1:0] {StIdle, StRun, StHalted, StTimeout} stateE;

    stateE stateQ, stateD;
    logic [CNT_W-1:0] cntQ [NUM_CNT];
    logic [CNT_W-1:0] cntD [NUM_CNT];
    logic [NUM_CNT-1:0] ovfQ, ovfD;
    logic [CNT_W-1:0] rdDataQ, rdDataD;
    logic [NUM_CNT-1:0] hit;
    logic countEn;
    logic wdHit;

    // Top bit of the hit vector is the cycle counter, which ticks every RUN cycle.
    assign hit     = {1'b1, event_i};
    assign countEn = (stateQ == StRun);

    always_comb begin
        ovfD = ovfQ;
        for (int i = 0; i < NUM_CNT; i++) begin
            cntD[i] = cntQ[i];
            if (countEn && hit[i]) begin
                if (&cntQ[i]) begin
                    ovfD[i] = 1'b1;
                    cntD[i] = sat_mode_i ? {CNT_W{1'b1}} : {CNT_W{1'b0}};
                end else begin
                    cntD[i] = cntQ[i] + CntOne;
                end
            end
        end
    end

    // Watchdog compares the post-increment cycle count in a wide domain so a limit
    // that does not fit in CNT_W simply never fires.
    assign wdHit = (CYCLE_LIMIT != 0) && countEn && (64'(cntD[NUM_EVENTS]) == CycleLimit);

    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            StIdle: begin
                if (en_i) stateD = StRun;
            end
            StRun: begin
                if (halt_i)     stateD = StHalted;
                else if (wdHit) stateD = StTimeout;
                else if (!en_i) stateD = StIdle;
            end
            StHalted:  stateD = StHalted;
            StTimeout: stateD = StTimeout;
            default:   stateD = StIdle;
        endcase
    end

    always_comb begin
        rdDataD = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (rd_sel_i == SEL_W'(i)) rdDataD = cntQ[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            stateQ  <= StIdle;
            ovfQ    <= '0;
            rdDataQ <= '0;
            for (int i = 0; i < NUM_CNT; i++) cntQ[i] <= '0;
        end else begin
            stateQ  <= stateD;
            ovfQ    <= ovfD;
            rdDataQ <= rdDataD;
            for (int i = 0; i < NUM_CNT; i++) cntQ[i] <= cntD[i];
        end
    end

    assign rd_data_o = rdDataQ;
    assign ovf_o     = ovfQ;
    assign running_o = (stateQ == StRun);
    assign frozen_o  = (stateQ == StHalted) || (stateQ == StTimeout);
    assign timeout_o = (stateQ == StTimeout);

endmodule

// File: tb/tb_perf_counter_bank.sv
// Scoreboard bench: dutA (32-bit, watchdog at 20) and dutB (4-bit, no watchdog)
// share stimulus; expectations are queued and checked by a negedge monitor.
module tb_perf_counter_bank;

    localparam int KRdA = 0, KRdB = 1, KRun = 2, KFroz = 3, KTo = 4, KOvfA = 5, KOvfB = 6;

    typedef struct {
        int          due;
        int          kind;
        logic [31:0] exp;
        string       tag;
    } chkT;

    logic clk = 1'b0;
    logic rst, en, clear, sat, halt;
    logic [7:0] ev;
    logic [3:0] rdSel;
    logic [31:0] rdA;
    logic [3:0] rdB;
    logic runA, frozA, toA, runB, frozB, toB;
    logic [8:0] ovfA, ovfB;

    int cyc = 0;
    int total = 0;
    int bad = 0;
    chkT q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    perf_counter_bank #(.NUM_EVENTS(8), .CNT_W(32), .CYCLE_LIMIT(20)) dutA (
        .clk(clk), .rst(rst), .en_i(en), .clear_i(clear), .sat_mode_i(sat), .event_i(ev),
        .halt_i(halt), .rd_sel_i(rdSel), .rd_data_o(rdA), .running_o(runA),
        .frozen_o(frozA), .timeout_o(toA), .ovf_o(ovfA)
    );

    perf_counter_bank #(.NUM_EVENTS(8), .CNT_W(4), .CYCLE_LIMIT(0)) dutB (
        .clk(clk), .rst(rst), .en_i(en), .clear_i(clear), .sat_mode_i(sat), .event_i(ev),
        .halt_i(halt), .rd_sel_i(rdSel), .rd_data_o(rdB), .running_o(runB),
        .frozen_o(frozB), .timeout_o(toB), .ovf_o(ovfB)
    );

    function automatic logic [31:0] sample(input int kind);
        case (kind)
            KRdA:    return rdA;
            KRdB:    return 32'(rdB);
            KRun:    return 32'(runA);
            KFroz:   return 32'(frozA);
            KTo:     return 32'(toA);
            KOvfA:   return 32'(ovfA);
            default: return 32'(ovfB);
        endcase
    endfunction

    // Monitor: pops every expectation that has come due and compares it.
    always @(negedge clk) begin
        chkT c;
        logic [31:0] act;
        while (q.size() > 0 && q[0].due <= cyc) begin
            c   = q.pop_front();
            act = sample(c.kind);
            total++;
            if (act !== c.exp) begin
                bad++;
                $display("FAIL %s: got %0h want %0h", c.tag, act, c.exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Read expectation: value appears after the next edge.
    task automatic expRd(input int kind, input int sel, input logic [31:0] exp, input string tag);
        chkT c;
        rdSel = 4'(sel);
        c.due = cyc + 1; c.kind = kind; c.exp = exp; c.tag = tag;
        q.push_back(c);
        tick();
    endtask

    // Flag expectation: checked against the current registered state.
    task automatic expFlag(input int kind, input logic [31:0] exp, input string tag);
        chkT c;
        c.due = cyc; c.kind = kind; c.exp = exp; c.tag = tag;
        q.push_back(c);
    endtask

    task automatic doClear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        logic enSeq [6];
        rst = 1'b1; en = 1'b0; clear = 1'b0; sat = 1'b0; halt = 1'b0; ev = '0; rdSel = '0;
        tick();
        tick();
        expFlag(KRun, 0, "rst_running");
        expFlag(KFroz, 0, "rst_frozen");
        expFlag(KTo, 0, "rst_timeout");
        expFlag(KOvfA, 0, "rst_ovf");
        expRd(KRdA, 8, 0, "rst_rd");
        rst = 1'b0;

        // Halt after 12 RUN cycles
        en = 1'b1;
        tick();
        expFlag(KRun, 1, "t1_running");
        for (int c = 1; c <= 12; c++) begin
            ev = '0;
            ev[0] = (c <= 10);
            ev[3] = (c <= 4);
            halt = (c == 12);
            tick();
        end
        halt = 1'b0;
        ev = '1;
        tick();
        tick();
        ev = '0;
        expFlag(KFroz, 1, "t1_frozen");
        expFlag(KTo, 0, "t1_timeout");
        expFlag(KRun, 0, "t1_running_off");
        expRd(KRdA, 0, 10, "t1_cnt0");
        expRd(KRdA, 3, 4, "t1_cnt3");
        expRd(KRdA, 8, 12, "t1_cycles");
        expRd(KRdA, 1, 0, "t1_cnt1");

        // 4-bit overflow: wrap then saturate
        for (int m = 0; m < 2; m++) begin
            en = 1'b0;
            doClear();
            expFlag(KOvfB, 0, "t2_ovf_clr");
            sat = (m == 1);
            en = 1'b1;
            tick();
            for (int c = 1; c <= 17; c++) begin
                ev = 8'h02;
                en = (c < 17);
                tick();
            end
            ev = '0;
            expRd(KRdB, 1, (m == 1) ? 32'd15 : 32'd1, "t2_cnt1");
            expRd(KRdB, 8, (m == 1) ? 32'd15 : 32'd1, "t2_cycles");
            expFlag(KOvfB, 32'h102, "t2_ovf");
        end
        sat = 1'b0;

        // Watchdog at 20 cycles
        doClear();
        en = 1'b1;
        tick();
        for (int c = 1; c <= 20; c++) tick();
        expFlag(KTo, 1, "t3_timeout");
        expFlag(KFroz, 1, "t3_frozen");
        expFlag(KRun, 0, "t3_running");
        tick();
        tick();
        expRd(KRdA, 8, 20, "t3_cycles_hold");

        // Halt coincident with watchdog
        doClear();
        en = 1'b1;
        tick();
        for (int c = 1; c <= 20; c++) begin
            halt = (c == 20);
            tick();
        end
        halt = 1'b0;
        expFlag(KTo, 0, "t3b_timeout");
        expFlag(KFroz, 1, "t3b_frozen");
        expRd(KRdA, 8, 20, "t3b_cycles");

        // Clear with halt and all events mid-run
        doClear();
        en = 1'b1;
        tick();
        ev = '1;
        for (int c = 0; c < 5; c++) tick();
        clear = 1'b1;
        halt = 1'b1;
        expRd(KRdA, 0, 0, "t4_rd_on_clear");
        clear = 1'b0; halt = 1'b0; ev = '0; en = 1'b0;
        expFlag(KRun, 0, "t4_running");
        expFlag(KFroz, 0, "t4_frozen");
        expFlag(KOvfA, 0, "t4_ovf");
        expRd(KRdA, 0, 0, "t4_cnt0");
        expRd(KRdA, 8, 0, "t4_cycles");

        // Reset mid-run; out-of-range select
        doClear();
        en = 1'b1;
        tick();
        ev = 8'h04;
        for (int c = 0; c < 7; c++) tick();
        ev = '0;
        expRd(KRdA, 2, 7, "t5_cnt2_pre");
        expRd(KRdA, 9, 0, "t5_sel9");
        expRd(KRdA, 15, 0, "t5_sel15");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        en = 1'b0;
        expFlag(KRun, 0, "t5_running");
        expRd(KRdA, 2, 0, "t5_cnt2_post");

        // en toggling: only RUN cycles count
        doClear();
        enSeq = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        ev = 8'h01;
        for (int c = 0; c < 6; c++) begin
            en = enSeq[c];
            tick();
        end
        tick();
        tick();
        ev = '0;
        expRd(KRdA, 0, 3, "t6_cnt0");
        expRd(KRdA, 8, 3, "t6_cycles");

        for (int w = 0; w < 10 && q.size() > 0; w++) tick();
        if (q.size() > 0) begin
            $display("FAIL drain: pending=%0d want 0", q.size());
            bad++;
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/perf_counter_bank.md
# perf_counter_bank

Synthesizable performance-monitor block that replaces the bench-only instruction/cache-hit/cache-request tallies with in-design counters. It counts up to NUM_EVENTS single-cycle event strobes plus a cycle counter, and freezes all counts on processor halt or on a cycle-limit watchdog. Counter width, overflow behaviour (wrap or saturate) and event count are configurable. It sits beside the cpu top level, takes event strobes from the pipeline/cache stall logic, and exposes a registered read port for stats dump.

## Interface
- NUM_EVENTS, 8, number of event channels (1..15)
- CNT_W, 32, width of every counter including cycle counter
- CYCLE_LIMIT, 100000, watchdog cycle count; 0 disables watchdog
- SEL_W, $clog2(NUM_EVENTS+1), read-select width (derived, not overridden)

- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- en_i  in  1  start/continue counting (level)
- clear_i  in  1  synchronous clear of all counters, flags and state
- sat_mode_i  in  1  1 = saturate at all-ones, 0 = wrap to zero
- event_i  in  NUM_EVENTS  per-channel event strobe, one count per high cycle
- halt_i  in  1  processor halt indication
- rd_sel_i  in  SEL_W  0..NUM_EVENTS-1 selects event counter, NUM_EVENTS selects cycle counter
- rd_data_o  out  CNT_W  registered read data
- running_o  out  1  state is RUN
- frozen_o  out  1  state is HALTED or TIMEOUT
- timeout_o  out  1  state is TIMEOUT
- ovf_o  out  NUM_EVENTS+1  sticky overflow flag per counter; bit NUM_EVENTS = cycle counter

## Operation
- States: IDLE, RUN, HALTED, TIMEOUT.
- IDLE: no counting. en_i=1 -> RUN next cycle; the en_i cycle itself is not counted.
- RUN: each cycle cycle counter +1; each counter i +1 when event_i[i]=1. en_i=0 -> IDLE next cycle (counts retained, current cycle counted).
- halt_i=1 in RUN: that cycle's events and cycle are counted, then -> HALTED. HALTED holds all counts until clear_i or rst.
- Watchdog: in RUN, when cycle counter post-increment value equals CYCLE_LIMIT (CYCLE_LIMIT != 0) -> TIMEOUT; that cycle counted. TIMEOUT holds counts.
- halt_i and watchdog in same cycle -> HALTED (halt wins).
- halt_i outside RUN ignored.
- Overflow: increment from all-ones sets ovf bit (sticky). sat_mode_i=1: counter stays all-ones. sat_mode_i=0: counter becomes 0. sat_mode_i sampled every cycle.
- clear_i: all counters, ovf_o, rd_data_o -> 0, state -> IDLE; events in that cycle dropped. clear_i overrides halt_i, en_i, event_i.
- Read: rd_data_o <= selected counter value (pre-update value of the current edge). rd_sel_i > NUM_EVENTS returns 0. Read port works in every state.

## Timing
- Reset (rst=1 at edge): state IDLE, all counters 0, ovf_o 0, rd_data_o 0, running_o 0, frozen_o 0, timeout_o 0. Reset mid-run discards all counts.
- running_o/frozen_o/timeout_o are decodes of the registered state (valid the cycle after the transition edge).
- Read latency 1 cycle: rd_sel_i presented before edge N -> rd_data_o valid after edge N showing count as of before edge N.
- Counter update latency 1 cycle: event at edge N visible via rd_data_o after edge N+1.
- Priority per edge: rst > clear_i > halt_i > watchdog > en_i deassert > counting.

## Test plan
- Reset then en_i=1, event_i[0] high 10 cycles, event_i[3] high 4 cycles, halt_i on cycle 12 of RUN -> HALTED, counter0=10, counter3=4, cycle counter=12, frozen_o=1; further events change nothing.
- CNT_W=4, wrap mode, 17 events on channel 1 -> counter1=1, ovf_o[1]=1; same with sat_mode_i=1 -> counter1=15, ovf_o[1]=1.
- CYCLE_LIMIT=20, en_i held, no halt -> after 20 RUN cycles timeout_o=1, cycle counter=20 and holds; halt_i on cycle 20 instead -> HALTED, timeout_o=0.
- clear_i asserted together with halt_i and event_i all ones mid-run -> all counters 0, ovf_o 0, state IDLE, running_o=0 next cycle.
- rst asserted mid-run with counter2=7 -> counter2 reads 0 afterwards, state IDLE; rd_sel_i=NUM_EVENTS+1 -> rd_data_o=0.
- en_i toggled 1,1,0,0,1 with event_i[0] always high -> counter0 counts only RUN cycles (3), cycle counter=3.
